// File: rtl/imm_decode_stage.sv
// Registered RV32/RV64 immediate decoder with a valid/ready handshake, a 2-entry
// skid buffer, a synchronous flush and a saturating illegal-instruction counter.
module imm_decode_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6, FMT_ILL = 3'd7;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [6:0]              opc;
    logic [2:0]              f3;
    logic signed [63:0]      imm_w_p0;
    logic signed [XLEN-1:0]  imm_p0;
    logic [2:0]              fmt_p0;
    logic                    ill_p0;

    assign opc = instruction[6:0];
    assign f3  = instruction[14:12];

    // Stage p0: combinational decode of the incoming word, built at 64 bits then narrowed
    always_comb begin
        imm_w_p0 = '0;
        fmt_p0   = FMT_R;
        ill_p0   = 1'b0;
        case (opc)
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt_p0   = FMT_SH;
                    imm_w_p0 = (XLEN == 64) ? {58'b0, instruction[25:20]}
                                            : {59'b0, instruction[24:20]};
                end else begin
                    fmt_p0   = FMT_I;
                    imm_w_p0 = {{52{instruction[31]}}, instruction[31:20]};
                end
            end
            7'b0011011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt_p0   = FMT_SH;
                    imm_w_p0 = {59'b0, instruction[24:20]};
                end else begin
                    fmt_p0   = FMT_I;
                    imm_w_p0 = {{52{instruction[31]}}, instruction[31:20]};
                end
            end
            7'b0000011, 7'b1100111: begin
                fmt_p0   = FMT_I;
                imm_w_p0 = {{52{instruction[31]}}, instruction[31:20]};
            end
            7'b0100011: begin
                fmt_p0   = FMT_S;
                imm_w_p0 = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                fmt_p0   = FMT_B;
                imm_w_p0 = {{51{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt_p0   = FMT_U;
                imm_w_p0 = {{32{instruction[31]}}, instruction[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt_p0   = FMT_J;
                imm_w_p0 = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: fmt_p0 = FMT_R;
            default: begin
                fmt_p0 = FMT_ILL;
                ill_p0 = 1'b1;
            end
        endcase
    end

    assign imm_p0 = imm_w_p0[XLEN-1:0];

    logic signed [XLEN-1:0] imm_p1, sk_imm_p1;
    logic [2:0]             fmt_p1, sk_fmt_p1;
    logic                   ill_p1, sk_ill_p1;
    logic                   vld_p1, sk_vld_p1;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   accept;

    assign in_ready = ~sk_vld_p1;
    assign accept   = in_valid & in_ready;

    // Stage p1: main register drives the outputs; skid absorbs one word under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_p1    <= '0;
            fmt_p1    <= '0;
            ill_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            sk_imm_p1 <= '0;
            sk_fmt_p1 <= '0;
            sk_ill_p1 <= 1'b0;
            sk_vld_p1 <= 1'b0;
            cnt_p1    <= '0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
        end else begin
            if (!vld_p1 || out_ready) begin
                if (sk_vld_p1) begin
                    imm_p1    <= sk_imm_p1;
                    fmt_p1    <= sk_fmt_p1;
                    ill_p1    <= sk_ill_p1;
                    vld_p1    <= 1'b1;
                    sk_vld_p1 <= 1'b0;
                end else if (accept) begin
                    imm_p1 <= imm_p0;
                    fmt_p1 <= fmt_p0;
                    ill_p1 <= ill_p0;
                    vld_p1 <= 1'b1;
                end else begin
                    vld_p1 <= 1'b0;
                end
            end else if (accept) begin
                sk_imm_p1 <= imm_p0;
                sk_fmt_p1 <= fmt_p0;
                sk_ill_p1 <= ill_p0;
                sk_vld_p1 <= 1'b1;
            end
            if (accept && ill_p0) cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_valid     = vld_p1;
    assign out_imm       = imm_p1;
    assign out_fmt       = fmt_p1;
    assign out_illegal   = ill_p1;
    assign illegal_count = cnt_p1;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 64-bit instance (2-bit counter) and a 32-bit instance
// share stimulus and are checked against a queue-based reference model.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [1:0]  illegal_count;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [7:0]  illegal_count32;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(64), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
        .illegal_count(illegal_count)
    );

    imm_decode_stage #(.XLEN(32), .CNT_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instruction(instruction), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32),
        .illegal_count(illegal_count32)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm64;
        logic [63:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
    } ent_t;

    ent_t mq[$];
    int   cnt2 = 0;
    int   cnt8 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediates computed arithmetically from the field values, then reduced to xlen bits
    function automatic void ref_dec(input logic [31:0] w, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        longint v;
        logic [6:0] op;
        logic [2:0] f;
        op = w[6:0];
        f = w[14:12];
        v = 0;
        fmt = 3'd0;
        ill = 1'b0;
        case (op)
            7'h13, 7'h1B: begin
                if (f == 3'd1 || f == 3'd5) begin
                    fmt = 3'd6;
                    v = (op == 7'h13 && xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
                end else begin
                    fmt = 3'd1;
                    v = longint'(w[31:20]);
                    if (v >= 2048) v -= 4096;
                end
            end
            7'h03, 7'h67: begin
                fmt = 3'd1;
                v = longint'(w[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                fmt = 3'd2;
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                fmt = 3'd3;
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
                    longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: begin
                fmt = 3'd4;
                v = longint'(w[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            7'h6F: begin
                fmt = 3'd5;
                v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
                    longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            7'h33, 7'h3B: fmt = 3'd0;
            default: begin
                fmt = 3'd7;
                ill = 1'b1;
            end
        endcase
        imm = 64'(v);
        if (xlen == 32) imm = imm & 64'hFFFF_FFFF;
    endfunction

    task automatic model_step();
        ent_t e;
        logic [2:0] f32;
        logic i32;
        logic acc, drn;
        acc = in_valid && (mq.size() < 2) && !flush;
        drn = (mq.size() > 0) && out_ready;
        if (flush) begin
            mq.delete();
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                ref_dec(instruction, 64, e.imm64, e.fmt, e.ill);
                ref_dec(instruction, 32, e.imm32, f32, i32);
                mq.push_back(e);
                if (e.ill) begin
                    if (cnt2 < 3) cnt2++;
                    if (cnt8 < 255) cnt8++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("illegal_count", 64'(illegal_count), 64'(cnt2));
        chk("out_valid32", 64'(out_valid32), 64'(mq.size() > 0));
        chk("in_ready32", 64'(in_ready32), 64'(mq.size() < 2));
        chk("illegal_count32", 64'(illegal_count32), 64'(cnt8));
        if (mq.size() > 0) begin
            chk("out_imm", out_imm, mq[0].imm64);
            chk("out_fmt", 64'(out_fmt), 64'(mq[0].fmt));
            chk("out_illegal", 64'(out_illegal), 64'(mq[0].ill));
            chk("out_imm32", 64'(out_imm32), mq[0].imm32);
            chk("out_fmt32", 64'(out_fmt32), 64'(mq[0].fmt));
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid = iv;
        instruction = w;
        out_ready = ordy;
        flush = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        logic [31:0] w;
        logic [63:0] e64;
        logic [63:0] e32;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t tbl[11];
    logic [6:0] ops[12];

    initial begin
        int cbefore;
        logic [31:0] r;
        tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'hFE113C23, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFF8, 3'd2, 1'b0};
        tbl[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFC, 3'd3, 1'b0};
        tbl[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 3'd4, 1'b0};
        tbl[4]  = '{32'h0010006F, 64'h800, 64'h800, 3'd5, 1'b0};
        tbl[5]  = '{32'h03F09093, 64'd63, 64'd31, 3'd6, 1'b0};
        tbl[6]  = '{32'h41F0D09B, 64'd31, 64'd31, 3'd6, 1'b0};
        tbl[7]  = '{32'h00B50533, 64'h0, 64'h0, 3'd0, 1'b0};
        tbl[8]  = '{32'h00001017, 64'h1000, 64'h1000, 3'd4, 1'b0};
        tbl[9]  = '{32'h80002083, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_F800, 3'd1, 1'b0};
        tbl[10] = '{32'h0000007F, 64'h0, 64'h0, 3'd7, 1'b1};
        ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                7'h6F, 7'h33, 7'h3B, 7'h7F};

        // reset state
        #12;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_imm", out_imm, 64'd0);
        chk("rst out_fmt", 64'(out_fmt), 64'd0);
        chk("rst out_illegal", 64'(out_illegal), 64'd0);
        chk("rst count", 64'(illegal_count), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors, one per cycle with out_ready high
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, tbl[i].w, 1'b1, 1'b0);
            chk($sformatf("tbl%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d imm64", i), out_imm, tbl[i].e64);
            chk($sformatf("tbl%0d imm32", i), 64'(out_imm32), tbl[i].e32);
            chk($sformatf("tbl%0d fmt", i), 64'(out_fmt), 64'(tbl[i].fmt));
            chk($sformatf("tbl%0d ill", i), 64'(out_illegal), 64'(tbl[i].ill));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // backpressure: A, B accepted, C held until space frees
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        chk("bp A imm", out_imm, 64'd1);
        chk("bp ready1", 64'(in_ready), 64'd1);
        cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
        chk("bp ready2", 64'(in_ready), 64'd0);
        chk("bp A stable", out_imm, 64'd1);
        cycle(1'b1, 32'h00300093, 1'b0, 1'b0);
        chk("bp C held", 64'(in_ready), 64'd0);
        chk("bp A stable2", out_imm, 64'd1);
        cycle(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("bp B out", out_imm, 64'd2);
        cycle(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("bp C out", out_imm, 64'd3);
        chk("bp C valid", 64'(out_valid), 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp empty", 64'(out_valid), 64'd0);

        // flush with both entries full; the word offered during flush is dropped
        cycle(1'b1, 32'h00100093, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 1'b0, 1'b0);
        cbefore = cnt2;
        cycle(1'b1, 32'h0000007F, 1'b0, 1'b1);
        chk("flush valid", 64'(out_valid), 64'd0);
        chk("flush ready", 64'(in_ready), 64'd1);
        chk("flush count", 64'(illegal_count), 64'(cbefore));

        // asynchronous reset mid-stream
        cycle(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000007F, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", 64'(out_valid), 64'd0);
        chk("arst imm", out_imm, 64'd0);
        chk("arst fmt", 64'(out_fmt), 64'd0);
        chk("arst ill", 64'(out_illegal), 64'd0);
        chk("arst count", 64'(illegal_count), 64'd0);
        chk("arst ready", 64'(in_ready), 64'd1);
        mq.delete();
        cnt2 = 0;
        cnt8 = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // saturating counter on a 2-bit width
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
            chk($sformatf("sat%0d fmt", i), 64'(out_fmt), 64'd7);
            chk($sformatf("sat%0d ill", i), 64'(out_illegal), 64'd1);
            chk($sformatf("sat%0d count", i), 64'(illegal_count), 64'((i < 3) ? i + 1 : 3));
        end

        // randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            cycle(1'($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 11)]},
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
